collision_probe_ctrl: RTL and testbench

Per-frame collision probe sequencer for the player sprite. On a frame strobe it samples the player position, scroll offset and directional velocities. It then issues eight tile lookups to the world ROM (`world_rom2`) on a fixed schedule and folds the returned tile IDs into four registered blocked flags. It sits between the player/physics logic and the world ROM port, and replaces per-pixel scanning with a fixed 10-cycle probe sequence.

---
 rtl/collision_pkg.sv | 45 ++++
 rtl/cell_addr_calc.sv | 38 +++
 rtl/collision_probe_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_collision_probe_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/collision_pkg.sv
// Shared types and constants for the player collision probe sequencer and
// the cell address generator it shares with the renderer.
package collision_pkg;

  localparam int COORD_W    = 12;
  localparam int ADDR_W     = 13;
  localparam int X_MAX      = 639;
  localparam int Y_MAX      = 479;
  localparam int WORLD_COLS = 40;
  localparam int WORLD_PAGE = 1200;

  // One spare bit above the 11-bit screen range keeps X+15+63 from wrapping.
  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  // Bits [2:1] of the probe index select the direction flag it feeds.
  typedef enum logic [2:0] {
    PRB_R0,
    PRB_R1,
    PRB_L0,
    PRB_L1,
    PRB_D0,
    PRB_D1,
    PRB_U0,
    PRB_U1
  } probe_e;

  function automatic logic tile_solid(input logic [4:0] id);
    return (id & 5'd1) == 5'd0;
  endfunction

  // Net speed towards fwd, floored at 1 so a stationary sprite still tests contact.
  function automatic logic [5:0] reach(input logic [5:0] fwd, input logic [5:0] back);
    logic [5:0] net;
    net = (fwd > back) ? fwd - back : 6'd0;
    return (net == 6'd0) ? 6'd1 : net;
  endfunction

endpackage

// File: rtl/cell_addr_calc.sv
// Combinational world-cell address generator: screen pixel plus scroll column
// to a paged world ROM address, with an out-of-screen indication.
module cell_addr_calc
  import collision_pkg::*;
#(
  parameter int TILE_SH = 4,
  parameter int COLS    = WORLD_COLS,
  parameter int PAGE    = WORLD_PAGE
) (
  input  coord_t            x,
  input  coord_t            y,
  input  logic [9:0]        scroll_col,
  output logic [ADDR_W-1:0] addr,
  output logic              oob
);

  logic [10:0] col;
  logic [10:0] row;
  logic [10:0] col_page;
  logic [10:0] col_off;

  always_comb begin
    oob = (x < 0) || (y < 0) || (x > coord_t'(X_MAX)) || (y > coord_t'(Y_MAX));

    col      = {1'b0, scroll_col} + 11'(x[10:0] >> TILE_SH);
    row      = 11'(y[10:0] >> TILE_SH);
    col_page = col / 11'(COLS);
    col_off  = col % 11'(COLS);

    // Arithmetic is carried at ADDR_W bits, which is the required truncation.
    addr = ADDR_W'(col_off) + ADDR_W'(row) * ADDR_W'(COLS)
         + ADDR_W'(col_page) * ADDR_W'(PAGE);
    if (oob) begin
      addr = '0;
    end
  end

endmodule

// File: rtl/collision_probe_ctrl.sv
// Per-frame collision probe sequencer: eight fixed-schedule world ROM lookups
// around the player sprite, folded into four registered blocked flags.
module collision_probe_ctrl
  import collision_pkg::*;
#(
  parameter int SPRITE_W = 16,
  parameter int TILE_SH  = 4,
  parameter int COLS     = WORLD_COLS,
  parameter int PAGE     = WORLD_PAGE
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [9:0]        X_Pos,
  input  logic [9:0]        Y_Pos,
  input  logic [9:0]        scroll_col,
  input  logic [5:0]        Right_V,
  input  logic [5:0]        Left_V,
  input  logic [5:0]        Up_V,
  input  logic [5:0]        Down_V,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [4:0]        rom_data,
  output logic              busy,
  output logic              done,
  output logic              rightFlag,
  output logic              leftFlag,
  output logic              downFlag,
  output logic              upFlag
);

  localparam coord_t EDGE = coord_t'(SPRITE_W - 1);

  state_e state;
  state_e state_next;
  probe_e idx;
  logic   accept;

  logic [9:0] x_q, y_q, scroll_q;
  logic [5:0] reach_r_q, reach_l_q, reach_u_q, reach_d_q;

  probe_e     gen_idx;
  logic [9:0] gen_x, gen_y, gen_scroll;
  logic [5:0] gen_r, gen_l, gen_u, gen_d;
  coord_t     xs, ys;
  coord_t     probe_x, probe_y;

  logic [ADDR_W-1:0] calc_addr;
  logic              calc_oob;

  logic   addr_oob;
  logic   data_vld;
  logic   data_oob;
  probe_e data_idx;

  // Bit order {up, down, left, right} matches probe index bits [2:1].
  logic [3:0] shadow;
  logic [3:0] shadow_next;
  logic [3:0] flags;

  assign accept = (state == S_IDLE) && start;

  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (idx == PRB_U1) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Probe 0 is issued on the start edge itself, so it is built from live inputs.
  always_comb begin
    if (state == S_IDLE) begin
      gen_idx    = PRB_R0;
      gen_x      = X_Pos;
      gen_y      = Y_Pos;
      gen_scroll = scroll_col;
      gen_r      = reach(Right_V, Left_V);
      gen_l      = reach(Left_V, Right_V);
      gen_u      = reach(Up_V, Down_V);
      gen_d      = reach(Down_V, Up_V);
    end else begin
      gen_idx    = probe_e'(idx + 3'd1);
      gen_x      = x_q;
      gen_y      = y_q;
      gen_scroll = scroll_q;
      gen_r      = reach_r_q;
      gen_l      = reach_l_q;
      gen_u      = reach_u_q;
      gen_d      = reach_d_q;
    end
  end

  always_comb begin
    xs      = coord_t'(gen_x);
    ys      = coord_t'(gen_y);
    probe_x = xs;
    probe_y = ys;
    case (gen_idx)
      PRB_R0: begin probe_x = xs + EDGE + coord_t'(gen_r); probe_y = ys;                          end
      PRB_R1: begin probe_x = xs + EDGE + coord_t'(gen_r); probe_y = ys + EDGE;                   end
      PRB_L0: begin probe_x = xs - coord_t'(gen_l);        probe_y = ys;                          end
      PRB_L1: begin probe_x = xs - coord_t'(gen_l);        probe_y = ys + EDGE;                   end
      PRB_D0: begin probe_x = xs;                          probe_y = ys + EDGE + coord_t'(gen_d); end
      PRB_D1: begin probe_x = xs + EDGE;                   probe_y = ys + EDGE + coord_t'(gen_d); end
      PRB_U0: begin probe_x = xs;                          probe_y = ys - coord_t'(gen_u);        end
      PRB_U1: begin probe_x = xs + EDGE;                   probe_y = ys - coord_t'(gen_u);        end
    endcase
  end

  cell_addr_calc #(
    .TILE_SH (TILE_SH),
    .COLS    (COLS),
    .PAGE    (PAGE)
  ) u_cell_addr (
    .x          (probe_x),
    .y          (probe_y),
    .scroll_col (gen_scroll),
    .addr       (calc_addr),
    .oob        (calc_oob)
  );

  // Out-of-screen probes are blocked regardless of what the ROM returns.
  always_comb begin
    shadow_next = shadow;
    if (state == S_IDLE) begin
      shadow_next = '0;
    end
    if (data_vld && (data_oob || tile_solid(rom_data))) begin
      shadow_next[data_idx[2:1]] = 1'b1;
    end
  end

  // NOTE: the frame operands are not reset; they are always loaded on an
  // accepted start before anything reads them, so a reset adds nothing.
  always_ff @(posedge Clk) begin
    if (accept) begin
      x_q       <= X_Pos;
      y_q       <= Y_Pos;
      scroll_q  <= scroll_col;
      reach_r_q <= gen_r;
      reach_l_q <= gen_l;
      reach_u_q <= gen_u;
      reach_d_q <= gen_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      idx      <= PRB_R0;
      rom_addr <= '0;
      addr_oob <= 1'b0;
      data_vld <= 1'b0;
      data_oob <= 1'b0;
      data_idx <= PRB_R0;
      shadow   <= '0;
      flags    <= '0;
    end else begin
      state    <= state_next;
      shadow   <= shadow_next;
      data_vld <= (state == S_ISSUE);
      data_idx <= idx;
      data_oob <= addr_oob;
      if (accept || (state == S_ISSUE && idx != PRB_U1)) begin
        idx      <= gen_idx;
        rom_addr <= calc_addr;
        addr_oob <= calc_oob;
      end
      // Probe 7 data arrives in DRAIN, so the bypassed shadow is published here.
      if (state == S_DRAIN) begin
        flags <= shadow_next;
      end
    end
  end

  assign rightFlag = flags[0];
  assign leftFlag  = flags[1];
  assign downFlag  = flags[2];
  assign upFlag    = flags[3];

endmodule

// File: tb/tb_collision_probe_ctrl.sv
// Scoreboard bench for collision_probe_ctrl: directed frames with hand-derived
// probe addresses, done cycles and flag results.
module tb_collision_probe_ctrl;

  typedef struct packed {
    logic [31:0]      done_cyc;
    logic [3:0]       flags;     // {up, down, left, right}
    logic [7:0][12:0] addr;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [9:0]  X_Pos, Y_Pos, scroll_col;
  logic [5:0]  Right_V, Left_V, Up_V, Down_V;
  logic [12:0] rom_addr;
  logic [4:0]  rom_data;
  logic        busy, done, rightFlag, leftFlag, downFlag, upFlag;

  logic [4:0] rom [0:8191];
  exp_t       sb[$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;
  always @(posedge Clk) rom_data <= rom[rom_addr];

  collision_probe_ctrl dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start      (start),
    .X_Pos      (X_Pos),
    .Y_Pos      (Y_Pos),
    .scroll_col (scroll_col),
    .Right_V    (Right_V),
    .Left_V     (Left_V),
    .Up_V       (Up_V),
    .Down_V     (Down_V),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .rightFlag  (rightFlag),
    .leftFlag   (leftFlag),
    .downFlag   (downFlag),
    .upFlag     (upFlag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic rom_fill(input logic [4:0] v);
    for (int i = 0; i < 8192; i++) rom[i] = v;
  endtask

  task automatic set_in(input logic [9:0] x, input logic [9:0] y, input logic [9:0] sc,
                        input logic [5:0] r, input logic [5:0] l,
                        input logic [5:0] u, input logic [5:0] d);
    X_Pos = x; Y_Pos = y; scroll_col = sc;
    Right_V = r; Left_V = l; Up_V = u; Down_V = d;
  endtask

  // The result of a start raised in the current cycle is due 10 cycles later.
  task automatic push_exp(input logic [3:0] fl,
                          input logic [12:0] a0, input logic [12:0] a1,
                          input logic [12:0] a2, input logic [12:0] a3,
                          input logic [12:0] a4, input logic [12:0] a5,
                          input logic [12:0] a6, input logic [12:0] a7);
    exp_t e;
    e.done_cyc = 32'(cyc + 10);
    e.flags    = fl;
    e.addr     = {a7, a6, a5, a4, a3, a2, a1, a0};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [9:0] x, input logic [9:0] y, input logic [9:0] sc,
                       input logic [5:0] r, input logic [5:0] l,
                       input logic [5:0] u, input logic [5:0] d,
                       input logic [3:0] fl,
                       input logic [12:0] a0, input logic [12:0] a1,
                       input logic [12:0] a2, input logic [12:0] a3,
                       input logic [12:0] a4, input logic [12:0] a5,
                       input logic [12:0] a6, input logic [12:0] a7);
    set_in(x, y, sc, r, l, u, d);
    start = 1'b1;
    push_exp(fl, a0, a1, a2, a3, a4, a5, a6, a7);
    tick();
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("drain_timeout", sb.size(), 0);
    tick();
  endtask

  // Monitor: counts busy cycles, captures the eight issued addresses, and
  // compares each done against the oldest queued expectation.
  initial begin
    int   cnt;
    exp_t e;
    logic [7:0][12:0] cap;
    cnt = 0;
    cap = '0;
    forever begin
      @(negedge Clk);
      if (busy === 1'b1) begin
        cnt++;
        if (cnt <= 8) cap[cnt-1] = rom_addr;
      end else begin
        cnt = 0;
      end
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("busy_cycles", cnt, 10);
          check("flags_udlr", {upFlag, downFlag, leftFlag, rightFlag}, e.flags);
          for (int i = 0; i < 8; i++)
            check($sformatf("addr_probe%0d", i), cap[i], e.addr[i]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    rom_fill(5'd1);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_flags", {upFlag, downFlag, leftFlag, rightFlag}, 0);
    check("reset_rom_addr", rom_addr, 0);
    tick();
    Reset = 1'b0;
    tick();

    // Right wall: cell 487 also sits under probe 7 (x=115,y=199), so up is set too.
    rom_fill(5'd1); rom[487] = 5'd2;
    issue(100, 200, 0, 3, 0, 0, 0, 4'b1001, 487, 527, 486, 526, 526, 527, 486, 487);
    drain();

    // Floor row 13 solid with Y=200: the sprite's own bottom row is row 13.
    rom_fill(5'd1); rom[526] = 5'd4; rom[527] = 5'd4;
    issue(100, 200, 0, 0, 0, 0, 0, 4'b0111, 487, 527, 486, 526, 526, 527, 486, 487);
    drain();

    // Floor contact with Y=192; net left 21-5=16, equal vertical speeds give reach 1.
    issue(100, 192, 0, 5, 21, 3, 3, 4'b0100, 487, 487, 485, 485, 526, 527, 446, 447);
    drain();

    // Page wrap: x=47 at scroll 38 lands in column 40, page 1; up probes off-screen.
    rom_fill(5'd1); rom[1200] = 5'd6;
    issue(48, 0, 38, 0, 1, 0, 0, 4'b1010, 1202, 1202, 1200, 1200, 1241, 1241, 0, 0);
    drain();

    // Screen edge, all passable: left and up blocked only by being off-screen.
    rom_fill(5'd1);
    issue(0, 0, 0, 0, 2, 1, 0, 4'b1010, 1, 1, 0, 0, 40, 40, 0, 0);
    drain();

    // Busy handling: starts during ISSUE and DONE are ignored, the one after is taken.
    rom_fill(5'd1); rom[487] = 5'd2;
    issue(100, 200, 0, 3, 0, 0, 0, 4'b1001, 487, 527, 486, 526, 526, 527, 486, 487);
    repeat (4) tick();
    start = 1'b1; X_Pos = 10'd300;
    tick();
    start = 1'b0; X_Pos = 10'd100;
    repeat (4) tick();
    start = 1'b1;
    tick();
    push_exp(4'b1001, 487, 527, 486, 526, 526, 527, 486, 487);
    tick();
    start = 1'b0;
    drain();

    // Far corner: x=640 and y=480 are off-screen, x=639 and y=479 are not.
    rom_fill(5'd1);
    issue(624, 464, 0, 0, 0, 0, 0, 4'b0101, 0, 0, 1198, 1198, 0, 0, 1159, 1159);
    drain();

    // Reset mid-run discards the frame and clears the previous flags.
    rom_fill(5'd1); rom[487] = 5'd2;
    set_in(100, 200, 0, 3, 0, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_flags", {upFlag, downFlag, leftFlag, rightFlag}, 0);
    check("midreset_rom_addr", rom_addr, 0);
    tick();
    issue(100, 200, 0, 3, 0, 0, 0, 4'b1001, 487, 527, 486, 526, 526, 527, 486, 487);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
